// File: rtl/md_unit_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide unit.
// The master side is EX (requests); the slave side is md_unit (busy, HI/LO).
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU ops are enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;
  // What the completion edge does with the latched result.
  typedef enum logic [1:0] {K_LOAD, K_KEEP, K_ADD, K_SUB} kind_t;

  state_t             state_reg;
  kind_t              kind_reg;
  logic               busy_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic accept;
  logic is_mul, is_div, is_signed, is_madd, is_msub, is_mthi, is_mtlo;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_madd   = 1'b0;
    is_msub   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (bus.op)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_madd = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_madd = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; is_msub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; is_msub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign accept = bus.start & ~busy_reg & ~bus.cancel;

  // Extending to 2*WIDTH before multiplying gives the exact signed or
  // unsigned product in modular arithmetic.
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  assign mul_a   = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign mul_b   = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign product = mul_a * mul_b;

  // Sign-magnitude division; most-negative / -1 naturally yields
  // quotient = most-negative, remainder = 0.
  logic             neg_a, neg_b, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b, mag_b_safe, quo_mag, rem_mag, quo, rem;
  assign neg_a      = is_signed & bus.a[WIDTH-1];
  assign neg_b      = is_signed & bus.b[WIDTH-1];
  assign div_zero   = (bus.b == '0);
  assign mag_a      = neg_a ? -bus.a : bus.a;
  assign mag_b      = neg_b ? -bus.b : bus.b;
  assign mag_b_safe = div_zero ? WIDTH'(1) : mag_b;
  assign quo_mag    = mag_a / mag_b_safe;
  assign rem_mag    = mag_a % mag_b_safe;
  assign quo        = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
  assign rem        = neg_a ? -rem_mag : rem_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      kind_reg   <= K_LOAD;
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (is_mthi) hi_reg <= bus.a;
            if (is_mtlo) lo_reg <= bus.a;
            if (is_mul) begin
              result_reg <= product;
              count_reg  <= MULT_CNT;
              kind_reg   <= is_madd ? K_ADD : (is_msub ? K_SUB : K_LOAD);
              busy_reg   <= 1'b1;
              state_reg  <= S_BUSY;
            end else if (is_div) begin
              result_reg <= {rem, quo};
              count_reg  <= DIV_CNT;
              kind_reg   <= div_zero ? K_KEEP : K_LOAD;
              busy_reg   <= 1'b1;
              state_reg  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus.cancel) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else if (count_reg == CW'(1)) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
            case (kind_reg)
              K_LOAD:  {hi_reg, lo_reg} <= result_reg;
              K_ADD:   {hi_reg, lo_reg} <= {hi_reg, lo_reg} + result_reg;
              K_SUB:   {hi_reg, lo_reg} <= {hi_reg, lo_reg} - result_reg;
              default: ;
            endcase
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_md_unit;
  localparam int W = 32;
  localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6,
                         OP_MADD = 4'd7, OP_MSUBU = 4'd10;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; returns on the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    $display("[TB] issue op=%0d a=%h b=%h busy=%b hi=%h lo=%h", op, a, b, bus.busy, bus.hi, bus.lo);
  endtask

  // Counts falling edges with busy high, bounded at 100.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_multu;
    int n;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
    count_busy(n);
    tests++;
    if (n !== 5) begin fails++; $display("FAIL multu_busy: got %0d cycles, want 5", n); end
    tests++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL multu_result: hi=%h lo=%h, want hi=00000001 lo=fffffffe", bus.hi, bus.lo);
    end
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    count_busy(n);
    tests++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFF1) begin
      fails++; $display("FAIL mult_signed: hi=%h lo=%h, want hi=ffffffff lo=fffffff1", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
    count_busy(n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL div_busy: got %0d cycles, want 10", n); end
    tests++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL div_signed: hi=%h lo=%h, want hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
    end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    tests++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin
      fails++; $display("FAIL div_overflow: hi=%h lo=%h, want hi=00000000 lo=80000000", bus.hi, bus.lo);
    end
    issue(OP_DIVU, 32'd100, 32'd7);
    count_busy(n);
    tests++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      fails++; $display("FAIL divu: hi=%h lo=%h, want hi=00000002 lo=0000000e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h12345678;
    @(negedge clk);
    tests++;
    if (bus.hi !== 32'h12345678 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL mthi: hi=%h busy=%b, want hi=12345678 busy=0", bus.hi, bus.busy);
    end
    bus.op = OP_MTLO; bus.a = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    tests++;
    if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL mtlo: hi=%h lo=%h busy=%b, want hi=12345678 lo=9abcdef0 busy=0", bus.hi, bus.lo, bus.busy);
    end
    $display("[TB] mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_back_to_back;
    int n;
    issue(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    count_busy(n);
    tests++;
    if (n + 2 !== 5) begin fails++; $display("FAIL ignore_busy_len: got %0d cycles, want 5", n + 2); end
    tests++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
      fails++; $display("FAIL ignore_busy_result: hi=%h lo=%h, want hi=0 lo=0000000c", bus.hi, bus.lo);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.lo !== 32'd12) begin
      fails++; $display("FAIL ignore_busy_late: busy=%b lo=%h, want busy=0 lo=0000000c", bus.busy, bus.lo);
    end
  endtask

  task automatic test_divzero_cancel;
    int n;
    issue(OP_MTHI, 32'hAA, 32'h0);
    issue(OP_MTLO, 32'hBB, 32'h0);
    issue(OP_DIVU, 32'd1234, 32'h0);
    count_busy(n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL divzero_busy: got %0d cycles, want 10", n); end
    tests++;
    if (bus.hi !== 32'hAA || bus.lo !== 32'hBB) begin
      fails++; $display("FAIL divzero_keep: hi=%h lo=%h, want hi=000000aa lo=000000bb", bus.hi, bus.lo);
    end
    issue(OP_MULT, 32'd7, 32'd7);
    repeat (2) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL cancel_busy: busy=%b, want 0", bus.busy); end
    repeat (6) @(negedge clk);
    tests++;
    if (bus.lo !== 32'hBB || bus.hi !== 32'hAA) begin
      fails++; $display("FAIL cancel_keep: hi=%h lo=%h, want hi=000000aa lo=000000bb", bus.hi, bus.lo);
    end
    // cancel blocks a same-cycle start
    bus.cancel = 1'b1;
    issue(OP_MTHI, 32'h55, 32'h0);
    bus.cancel = 1'b0;
    tests++;
    if (bus.hi !== 32'hAA) begin fails++; $display("FAIL cancel_blocks_start: hi=%h, want 000000aa", bus.hi); end
    $display("[TB] divzero/cancel hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_reset_mid;
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      fails++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    repeat (12) @(negedge clk);
    tests++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      fails++; $display("FAIL reset_mid_late: hi=%h lo=%h, want hi=0 lo=0", bus.hi, bus.lo);
    end
    $display("[TB] reset mid-op done");
  endtask

  task automatic test_madd;
    int n;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'd10, 32'h0);
`ifdef MD_UNIT_MADD_EN
    issue(OP_MADD, 32'd3, 32'd4);
    count_busy(n);
    tests++;
    if (n !== 5 || bus.hi !== 32'h0 || bus.lo !== 32'd22) begin
      fails++; $display("FAIL madd: n=%0d hi=%h lo=%h, want n=5 hi=0 lo=00000016", n, bus.hi, bus.lo);
    end
    issue(OP_MSUBU, 32'd30, 32'd1);
    count_busy(n);
    tests++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFF8) begin
      fails++; $display("FAIL msubu: hi=%h lo=%h, want hi=ffffffff lo=fffffff8", bus.hi, bus.lo);
    end
`else
    issue(OP_MADD, 32'd3, 32'd4);
    count_busy(n);
    tests++;
    if (n !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'd10) begin
      fails++; $display("FAIL reserved_nop: n=%0d hi=%h lo=%h, want n=0 hi=0 lo=0000000a", n, bus.hi, bus.lo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_divzero_cancel();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts one operation per start pulse and asserts busy for a configurable latency.
- The hazard controller uses busy to stall ID when a HI/LO-touching instruction follows.
- Generalises the fixed single-cycle EX datapath with width, latency and cancel support.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >= 8).
- MULT_LAT, 5, busy cycles for MULT/MULTU (>= 1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (>= 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request qualifier from EX.
- op  in  4  operation code; sampled only when start=1. Codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-15 reserved.
- a  in  WIDTH  rs operand (already forwarded).
- b  in  WIDTH  rt operand (already forwarded).
- cancel  in  1  abort the in-flight operation (flush/exception).
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register, registered.
- lo  out  WIDTH  LO register, registered.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, internal counter=0, latched result=0. Reset mid-operation discards the operation; HI/LO are cleared.
- Accept condition: start=1 and busy=0 and cancel=0. When start=1 while busy=1, the request is ignored: no state change, counter not reloaded.
- MULT/MULTU:
  - On accept, compute the 2*WIDTH product (signed/unsigned), latch it internally, load counter=MULT_LAT.
  - busy=1 for exactly MULT_LAT cycles after the accept edge.
  - On the edge where counter goes 1->0: hi=product[2W-1:W], lo=product[W-1:0]. busy is 0 in the same cycle the new HI/LO are visible.
- DIV/DIVU:
  - Same timing with DIV_LAT. lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow (most-negative / -1): lo=most-negative, hi=0.
  - Divide by zero: busy runs the full DIV_LAT, and HI/LO are left unchanged at completion.
- MTHI/MTLO: on accept, hi=a (or lo=a) at that edge; busy stays 0; counter untouched.
- NOP/reserved: no effect.
- cancel:
  - When asserted with busy=1: counter=0, busy=0 next cycle, HI/LO not written.
  - A completion edge coinciding with cancel is suppressed (cancel wins).
  - cancel also blocks a same-cycle start.
- Reads: hi/lo are plain register outputs. MFHI/MFLO are performed by the EX mux, and the hazard unit stalls them while busy=1 or start=1.
- Counter width: clog2(max(MULT_LAT, DIV_LAT)+1).
- No combinational path from inputs to busy/hi/lo.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- When defined, adds op codes 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
  - Latency MULT_LAT.
  - At completion, {hi,lo} = {hi,lo} +/- product (2*WIDTH modulo arithmetic).
  - The {hi,lo} used is the value at the completion edge, after any cancel rules.
- When not defined, codes 7-10 are reserved and act as NOP. No extra logic or ports either way.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> busy=1 for 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE, busy=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each; busy stays 0.
- MULT 3*4 accepted; MULT 5*5 pulsed during busy cycle 2 -> ignored; final lo=12, hi=0, busy high exactly 5 cycles.
- DIVU b=0 with hi=0xAA, lo=0xBB preloaded -> busy 10 cycles; hi=0xAA, lo=0xBB unchanged. Second run: cancel on busy cycle 3 of MULT 7*7 -> busy=0 next cycle, lo unchanged.
- reset asserted on busy cycle 4 of a DIV -> next cycle busy=0, hi=0, lo=0. With MD_UNIT_MADD_EN: hi=0, lo=10, then MADD 3*4 -> lo=22; MSUBU 30*1 -> {hi,lo}=0xFFFFFFFF_FFFFFFF8.
